// File: rtl/pattern_pkg.sv
// Shared constants and FSM encoding for the pattern-stream frame receiver.
// Frame layout is three header ones followed by a two-bit payload, MSB first.
package pattern_pkg;

   localparam int FRAME_LEN = 5;
   localparam int HDR_LEN   = 3;
   localparam int PAY_LEN   = 2;
   localparam int IDX_W     = 3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RECV   = 2'd1;
   localparam logic [1:0] ST_RESYNC = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      RECV   = ST_RECV,
      RESYNC = ST_RESYNC
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg <= '0;
      end else if (clr) begin
         q_reg <= '0;
      end else if (inc && (q_reg != {W{1'b1}})) begin
         q_reg <= q_reg + 1'b1;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/pattern_rx.sv
// Serial frame receiver: aligns to 5-bit frames, emits 2-bit symbols with a strobe,
// flags header/abort errors and keeps saturating per-symbol occurrence counts.
module pattern_rx
   import pattern_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic               pattern,
   input  logic               clr,
   output logic [PAY_LEN-1:0] sym,
   output logic               sym_valid,
   output logic               hdr_err,
   output logic               abort_err,
   output logic [4*CNT_W-1:0] cnt
);

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic               msb_reg, msb_next;
   logic [PAY_LEN-1:0] sym_reg, sym_next;
   logic               sym_valid_reg, sym_valid_next;
   logic               hdr_err_reg, hdr_err_next;
   logic               abort_err_reg, abort_err_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         msb_reg       <= 1'b0;
         sym_reg       <= '0;
         sym_valid_reg <= 1'b0;
         hdr_err_reg   <= 1'b0;
         abort_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         msb_reg       <= msb_next;
         sym_reg       <= sym_next;
         sym_valid_reg <= sym_valid_next;
         hdr_err_reg   <= hdr_err_next;
         abort_err_reg <= abort_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      msb_next       = msb_reg;
      sym_next       = sym_reg;
      sym_valid_next = 1'b0;
      hdr_err_next   = 1'b0;
      abort_err_next = 1'b0;

      case (state_reg)
         IDLE: begin
            idx_next = '0;
            if (valid) begin
               if (pattern) begin
                  state_next = RECV;
                  idx_next   = IDX_W'(1);
               end else begin
                  hdr_err_next = 1'b1;
                  state_next   = RESYNC;
               end
            end
         end

         RECV: begin
            if (!valid) begin
               // Partial payload is dropped; sym keeps the last complete symbol.
               abort_err_next = 1'b1;
               state_next     = IDLE;
               idx_next       = '0;
            end else if (idx_reg < IDX_W'(HDR_LEN)) begin
               if (!pattern) begin
                  hdr_err_next = 1'b1;
                  state_next   = RESYNC;
                  idx_next     = '0;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end else if (idx_reg == IDX_W'(HDR_LEN)) begin
               msb_next = pattern;
               idx_next = idx_reg + 1'b1;
            end else begin
               // Last bit of the frame; IDLE takes the next valid bit as bit 0.
               sym_next       = {msb_reg, pattern};
               sym_valid_next = 1'b1;
               state_next     = IDLE;
               idx_next       = '0;
            end
         end

         RESYNC: begin
            idx_next = '0;
            if (!valid) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   assign sym       = sym_reg;
   assign sym_valid = sym_valid_reg;
   assign hdr_err   = hdr_err_reg;
   assign abort_err = abort_err_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
         logic inc;
         assign inc = sym_valid_reg && (sym_reg == PAY_LEN'(gi));

         sat_counter #(
            .W (CNT_W)
         ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc),
            .q   (cnt[gi*CNT_W +: CNT_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pattern_rx.sv
// Directed bench for pattern_rx: a per-cycle vector table plus hand-written
// sequences for saturation, clear priority and mid-frame reset.
module tb_pattern_rx;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid;
   logic             pattern;
   logic             clr;
   logic [1:0]       sym;
   logic             sym_valid;
   logic             hdr_err;
   logic             abort_err;
   logic [4*CNT_W-1:0] cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   pattern_rx #(
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .pattern   (pattern),
      .clr       (clr),
      .sym       (sym),
      .sym_valid (sym_valid),
      .hdr_err   (hdr_err),
      .abort_err (abort_err),
      .cnt       (cnt)
   );

   typedef struct {
      logic       v;
      logic       p;
      logic       c;
      logic [1:0] esym;
      logic       esv;
      logic       ehdr;
      logic       eab;
      logic [7:0] ecnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic p, input logic c, input logic [1:0] esym,
                      input logic esv, input logic ehdr, input logic eab, input logic [7:0] ecnt);
      vec_t r;
      r.v = v; r.p = p; r.c = c; r.esym = esym;
      r.esv = esv; r.ehdr = ehdr; r.eab = eab; r.ecnt = ecnt;
      vecs.push_back(r);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic v, input logic p, input logic c);
      valid = v; pattern = p; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [1:0] pay);
      logic [4:0] b;
      b = {3'b111, pay};
      for (int i = 4; i >= 0; i--) send_bit(1'b1, b[i], 1'b0);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; pattern = 1'b0; clr = 1'b0;

      // single frame, payload 10
      add(1,1,0, 2'b00,0,0,0, 8'h00);
      add(1,1,0, 2'b00,0,0,0, 8'h00);
      add(1,1,0, 2'b00,0,0,0, 8'h00);
      add(1,1,0, 2'b00,0,0,0, 8'h00);
      add(1,0,0, 2'b10,1,0,0, 8'h00);
      add(0,0,0, 2'b10,0,0,0, 8'h10);
      add(0,0,1, 2'b10,0,0,0, 8'h00);
      // back-to-back frames 00,01,10,11
      add(1,1,0, 2'b10,0,0,0, 8'h00);
      add(1,1,0, 2'b10,0,0,0, 8'h00);
      add(1,1,0, 2'b10,0,0,0, 8'h00);
      add(1,0,0, 2'b10,0,0,0, 8'h00);
      add(1,0,0, 2'b00,1,0,0, 8'h00);
      add(1,1,0, 2'b00,0,0,0, 8'h01);
      add(1,1,0, 2'b00,0,0,0, 8'h01);
      add(1,1,0, 2'b00,0,0,0, 8'h01);
      add(1,0,0, 2'b00,0,0,0, 8'h01);
      add(1,1,0, 2'b01,1,0,0, 8'h01);
      add(1,1,0, 2'b01,0,0,0, 8'h05);
      add(1,1,0, 2'b01,0,0,0, 8'h05);
      add(1,1,0, 2'b01,0,0,0, 8'h05);
      add(1,1,0, 2'b01,0,0,0, 8'h05);
      add(1,0,0, 2'b10,1,0,0, 8'h05);
      add(1,1,0, 2'b10,0,0,0, 8'h15);
      add(1,1,0, 2'b10,0,0,0, 8'h15);
      add(1,1,0, 2'b10,0,0,0, 8'h15);
      add(1,1,0, 2'b10,0,0,0, 8'h15);
      add(1,1,0, 2'b11,1,0,0, 8'h15);
      add(0,0,0, 2'b11,0,0,0, 8'h55);
      add(0,0,1, 2'b11,0,0,0, 8'h00);
      // header error on bit 1, ignored until valid gap, then payload 01
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,0,0, 2'b11,0,1,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(0,0,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b11,0,0,0, 8'h00);
      add(1,0,0, 2'b11,0,0,0, 8'h00);
      add(1,1,0, 2'b01,1,0,0, 8'h00);
      add(0,0,0, 2'b01,0,0,0, 8'h04);
      // abort after bit 3, then payload 10
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(0,0,0, 2'b01,0,0,1, 8'h04);
      add(0,0,0, 2'b01,0,0,0, 8'h04);
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(1,1,0, 2'b01,0,0,0, 8'h04);
      add(1,0,0, 2'b10,1,0,0, 8'h04);
      add(0,0,0, 2'b10,0,0,0, 8'h14);

      repeat (2) @(posedge clk);
      #1;
      check("rst_sym", {6'd0, sym}, 8'h00);
      check("rst_strobes", {5'd0, sym_valid, hdr_err, abort_err}, 8'h00);
      check("rst_cnt", cnt, 8'h00);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         send_bit(vecs[i].v, vecs[i].p, vecs[i].c);
         if (sym !== vecs[i].esym || sym_valid !== vecs[i].esv || hdr_err !== vecs[i].ehdr ||
             abort_err !== vecs[i].eab || cnt !== vecs[i].ecnt) begin
            failed++;
            $display("FAIL vec%0d: got sym=%b sv=%b hdr=%b ab=%b cnt=%h expected sym=%b sv=%b hdr=%b ab=%b cnt=%h",
                     i, sym, sym_valid, hdr_err, abort_err, cnt,
                     vecs[i].esym, vecs[i].esv, vecs[i].ehdr, vecs[i].eab, vecs[i].ecnt);
         end
         tests++;
      end

      // saturation at 3 with CNT_W=2
      send_bit(1'b0, 1'b0, 1'b1);
      check("sat_pre_clr", cnt, 8'h00);
      for (int f = 0; f < 5; f++) frame(2'b11);
      send_bit(1'b0, 1'b0, 1'b0);
      check("sat_cnt", cnt, 8'hC0);

      // clr coincident with sym_valid wins, strobe still fires
      frame(2'b11);
      check("clr_sv", {6'd0, sym_valid, 1'b0}, 8'h02);
      check("clr_sym", {6'd0, sym}, 8'h03);
      send_bit(1'b0, 1'b0, 1'b1);
      check("clr_cnt", cnt, 8'h00);
      send_bit(1'b0, 1'b0, 1'b0);
      check("clr_cnt_hold", cnt, 8'h00);

      frame(2'b01);
      send_bit(1'b0, 1'b0, 1'b0);
      check("pre_rst_cnt", cnt, 8'h04);
      check("pre_rst_sym", {6'd0, sym}, 8'h01);

      // asynchronous reset while bit 2 is presented
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0);
      valid = 1'b1; pattern = 1'b1;
      rst = 1'b1;
      #1;
      check("midrst_sym", {6'd0, sym}, 8'h00);
      check("midrst_strobes", {5'd0, sym_valid, hdr_err, abort_err}, 8'h00);
      check("midrst_cnt", cnt, 8'h00);
      valid = 1'b0;
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      frame(2'b10);
      check("post_rst_sym", {6'd0, sym}, 8'h02);
      check("post_rst_sv", {7'd0, sym_valid}, 8'h01);
      send_bit(1'b0, 1'b0, 1'b0);
      check("post_rst_cnt", cnt, 8'h10);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pattern_rx.md
# pattern_rx

Serial frame receiver that sits directly downstream of the pattern generator and consumes its pattern/valid bit stream. It aligns to 5-bit frames (three header 1s, then two payload bits, MSB first) and emits each decoded 2-bit symbol with a one-cycle strobe. It flags header and abort errors and keeps per-symbol saturating occurrence counts for the lab checker.

## Interface
- CNT_W, 8, width of each per-symbol occurrence counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- valid  in  1  serial bit qualifier from the generator
- pattern  in  1  serial data bit, sampled only when valid=1
- clr  in  1  synchronous clear of all occurrence counters
- sym  out  2  last decoded payload {bit3, bit4}
- sym_valid  out  1  one-cycle strobe: sym updated this cycle
- hdr_err  out  1  one-cycle strobe: header bit was 0
- abort_err  out  1  one-cycle strobe: valid dropped mid-frame
- cnt  out  4*CNT_W  packed counters, cnt[k*CNT_W +: CNT_W] = occurrences of sym==k

## Operation
- Frame = 5 consecutive valid-high cycles: bits 0..2 must be 1 (header), bit 3 = payload MSB, bit 4 = payload LSB.
- FSM states: IDLE, RECV, RESYNC. A 3-bit bit index idx (0..4) tracks position. Payload MSB is held in a 1-bit register.
- IDLE: valid=0 → stay. valid=1 & pattern=1 → RECV, idx=1. valid=1 & pattern=0 → hdr_err, RESYNC.
- RECV, valid=0 → abort_err, IDLE. Partial payload is discarded and sym is unchanged.
- RECV, idx 1..2: pattern=0 → hdr_err, RESYNC. Otherwise idx+1.
- RECV, idx 3: capture the MSB, idx=4.
- RECV, idx 4: sym <= {msb, pattern}, sym_valid, → IDLE.
- Back-to-back frames: the IDLE logic treats a valid-high bit in the cycle after idx 4 as bit 0, so there is no gap requirement.
- RESYNC: ignore all bits while valid=1. valid=0 → IDLE. Realignment happens only on a valid low gap.
- Counters:
  - On sym_valid, cnt[sym] increments.
  - Saturates at 2^CNT_W−1, with no wrap.
  - clr zeroes all four counters. clr in the same cycle as sym_valid wins: the symbol is not counted, but the sym/sym_valid outputs still fire.
- Error strobes are mutually exclusive with sym_valid by construction.

## Timing
- All outputs are registered. Reset values: sym=2'b00, sym_valid=0, hdr_err=0, abort_err=0, cnt=0, FSM=IDLE, idx=0.
- Latency: sym/sym_valid assert on the clock edge that samples bit 4, so they are visible the cycle after bit 4 is presented on the inputs. The counter value reflects the symbol one cycle after sym_valid.
- hdr_err and abort_err assert on the edge that samples the offending bit or the valid drop. Each is high for exactly one cycle.
- Continuous valid=1 gives one sym_valid every 5 cycles.
- rst asserted mid-frame: immediate return to IDLE with all outputs at reset values. The first frame after release is decoded from its own bit 0.

## Structure
- Shared package pattern_pkg holds:
  - FRAME_LEN=5, HDR_LEN=3, PAY_LEN=2
  - FSM state encoding (IDLE, RECV, RESYNC) as 2-bit localparams
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) is instanced 4×, with inc = sym_valid & (sym==k).

## Test plan
- Single frame: valid=1 for 5 cycles, pattern 1,1,1,1,0 → sym=2'b10, one sym_valid, cnt[2]=1, others 0.
- Back-to-back: valid held high for 20 cycles with payloads 00,01,10,11 → four sym_valid strobes exactly 5 cycles apart, each cnt=1.
- Header error: bits 1,0,… with valid high for 7 cycles, then valid low, then a good frame with payload 01 →
  - one hdr_err on the 2nd bit
  - no output until after the low gap
  - then sym=01
- Abort: valid drops after bit 3 → one abort_err, sym unchanged, no counter change. The next full frame decodes normally.
- Saturation and clear, CNT_W=2: five frames of payload 11 → cnt[3] stops at 3. clr coincident with a 6th sym_valid → cnt[3]=0.
- Reset mid-frame: rst pulse at bit 2 → all outputs 0. A following frame with payload 10 decodes to sym=10.
